// File: rtl/instr_sequencer.sv
// Instruction sequencer: fetches 24-bit words from a synchronous instruction
// memory, decodes them and hands MATMUL/VADD/VMOV operations to an execution unit.
module instr_sequencer #(
  parameter int INSTR_WIDTH = 24,
  parameter int PC_WIDTH    = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_data,
  output logic                   op_valid,
  input  logic                   op_ready,
  output logic [5:0]             op_code,
  output logic [4:0]             op_src_a,
  output logic [4:0]             op_src_b,
  output logic [4:0]             op_dst,
  output logic [2:0]             op_arg,
  input  logic                   op_done,
  output logic                   busy,
  output logic                   halted,
  output logic                   illegal,
  output logic [PC_WIDTH-1:0]    pc,
  output logic [7:0]             retired
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_ISSUE,
    S_EXEC,
    S_HALT,
    S_ERROR
  } state_t;

  typedef enum logic [5:0] {
    OP_NOP    = 6'd0,
    OP_MATMUL = 6'd1,
    OP_VADD   = 6'd2,
    OP_VMOV   = 6'd3,
    OP_HALT   = 6'd10
  } opcode_t;

  state_t state, state_next;
  logic   pc_inc, pc_clr, ret_inc, fields_load;

  logic [5:0] dec_code;
  assign dec_code = imem_data[23:18];

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next  = state;
    pc_inc      = 1'b0;
    pc_clr      = 1'b0;
    ret_inc     = 1'b0;
    fields_load = 1'b0;
    case (state)
      S_IDLE:   if (start) state_next = S_FETCH;
      S_FETCH:  state_next = S_DECODE;
      S_DECODE: begin
        fields_load = 1'b1;
        case (dec_code)
          OP_NOP: begin
            pc_inc     = 1'b1;
            state_next = S_FETCH;
          end
          OP_MATMUL, OP_VADD, OP_VMOV: state_next = S_ISSUE;
          OP_HALT:                     state_next = S_HALT;
          default:                     state_next = S_ERROR;
        endcase
      end
      S_ISSUE:  if (op_ready) state_next = S_EXEC;
      S_EXEC: begin
        if (op_done) begin
          pc_inc     = 1'b1;
          ret_inc    = 1'b1;
          state_next = S_FETCH;
        end
      end
      S_HALT: begin
        if (start) begin
          pc_clr     = 1'b1;
          state_next = S_FETCH;
        end
      end
      S_ERROR:  state_next = S_ERROR;
      default:  state_next = S_IDLE;
    endcase
  end

  // pc/retired/decoded fields; pc wraps naturally at 2^PC_WIDTH
  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= '0;
      retired  <= '0;
      op_code  <= '0;
      op_src_a <= '0;
      op_src_b <= '0;
      op_dst   <= '0;
      op_arg   <= '0;
    end else begin
      if (pc_clr)      pc <= '0;
      else if (pc_inc) pc <= pc + PC_WIDTH'(1);
      if (ret_inc && (retired != 8'hFF)) retired <= retired + 8'd1;
      if (fields_load) begin
        op_code  <= imem_data[23:18];
        op_src_a <= imem_data[17:13];
        op_src_b <= imem_data[12:8];
        op_dst   <= imem_data[7:3];
        op_arg   <= imem_data[2:0];
      end
    end
  end

  assign imem_addr = pc;
  assign op_valid  = (state == S_ISSUE);
  assign busy      = (state == S_FETCH) || (state == S_DECODE) ||
                     (state == S_ISSUE) || (state == S_EXEC);
  assign halted    = (state == S_HALT);
  assign illegal   = (state == S_ERROR);

endmodule
